// File: rtl/riscv_data_bus.sv
// Data-side memory unit for the RV32I core: word RAM with byte-lane steering, alignment and
// range checking, registered load data. Optional machine timer under `RISCV_MTIMER_EN.
module riscv_data_bus #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE  = 32'hFFFF_FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [1:0]  width,
    input  logic [31:0] write_data,
    input  logic        read,
    input  logic        write,
    output logic [31:0] read_data,
    output logic        bus_error,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic          access;
    logic          align_ok;
    logic          in_ram;
    logic          in_timer;
    logic          ram_hit;
    logic          timer_ok;
    logic          err;
    logic [AW-1:0] word_idx;
    logic [3:0]    be;
    logic [31:0]   wr_lanes;
    logic          ram_we;
    logic [31:0]   ram_word;
    logic [31:0]   ram_shifted;
    logic [31:0]   ram_load;
    logic [31:0]   timer_rdata;

    logic [31:0] read_data_q, read_data_d;
    logic        bus_error_q, bus_error_d;

    assign access   = read | write;
    assign in_ram   = (address >> (AW + 2)) == 32'd0;
    assign in_timer = address[31:4] == TIMER_BASE[31:4];
    assign word_idx = address[AW+1:2];

    always_comb begin
        align_ok = 1'b0;
        unique case (width)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~address[0];
            2'd2:    align_ok = (address[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

`ifdef RISCV_MTIMER_EN
    assign timer_ok = in_timer & (width == 2'd2) & (address[1:0] == 2'b00);
`else
    assign timer_ok = 1'b0;
`endif

    // The timer page is never RAM, so its accesses fail unless the timer claims them.
    assign ram_hit = access & in_ram & align_ok & ~in_timer;
    assign err     = access & ~ram_hit & ~timer_ok;

    always_comb begin
        be       = 4'b0000;
        wr_lanes = write_data;
        unique case (width)
            2'd0: begin
                be       = 4'b0001 << address[1:0];
                wr_lanes = {4{write_data[7:0]}};
            end
            2'd1: begin
                be       = address[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{write_data[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wr_lanes = write_data;
            end
        endcase
    end

    // A store sampled together with reset assertion is dropped.
    assign ram_we = write & ram_hit & ~reset;

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    assign ram_word    = mem[word_idx];
    assign ram_shifted = ram_word >> {address[1:0], 3'b000};

    always_comb begin
        ram_load = ram_shifted;
        unique case (width)
            2'd0:    ram_load = {24'd0, ram_shifted[7:0]};
            2'd1:    ram_load = {16'd0, ram_shifted[15:0]};
            default: ram_load = ram_shifted;
        endcase
    end

`ifdef RISCV_MTIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q;
    logic        timer_we;

    assign timer_we = write & timer_ok & ~reset;

    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (timer_we) begin
            unique case (address[3:2])
                2'd0: mtime_d    = {mtime_q[63:32], write_data};
                2'd1: mtime_d    = {write_data, mtime_q[31:0]};
                2'd2: mtimecmp_d = {mtimecmp_q[63:32], write_data};
                2'd3: mtimecmp_d = {write_data, mtimecmp_q[31:0]};
            endcase
        end
    end

    always_comb begin
        timer_rdata = 32'd0;
        unique case (address[3:2])
            2'd0: timer_rdata = mtime_q[31:0];
            2'd1: timer_rdata = mtime_q[63:32];
            2'd2: timer_rdata = mtimecmp_q[31:0];
            2'd3: timer_rdata = mtimecmp_q[63:32];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign irq = irq_q;
`else
    assign timer_rdata = 32'd0;
    assign irq         = 1'b0;
`endif

    always_comb begin
        read_data_d = read_data_q;
        bus_error_d = bus_error_q | err;
        if (err) begin
            read_data_d = 32'd0;
        end else if (read) begin
            read_data_d = ram_hit ? ram_load : timer_rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data_q <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            read_data_q <= read_data_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign read_data = read_data_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_riscv_data_bus.sv
// Directed bench for riscv_data_bus: load expectations go through a scoreboard queue and are
// compared when the registered load data appears.
module tb_riscv_data_bus;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [1:0]  width;
    logic [31:0] write_data;
    logic        read;
    logic        write;
    logic [31:0] read_data;
    logic        bus_error;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    riscv_data_bus dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .width      (width),
        .write_data (write_data),
        .read       (read),
        .write      (write),
        .read_data  (read_data),
        .bus_error  (bus_error),
        .irq        (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one request, which is sampled at the next posedge.
    task automatic acc(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] w,
                       input logic [31:0] wd, input logic [31:0] exp, input string tag);
        read       = rd;
        write      = wr;
        address    = a;
        width      = w;
        write_data = wd;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        if (rd) check(tag_q.pop_front(), read_data, exp_q.pop_front());
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd);
        acc(1'b0, 1'b1, a, w, wd, 32'd0, "store");
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] w, input logic [31:0] exp,
                      input string tag);
        acc(1'b1, 1'b0, a, w, 32'd0, exp, tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] held;
        bit          seen;

        read = 1'b0; write = 1'b0; address = 32'd0; width = 2'd0; write_data = 32'd0;
        reset = 1'b1;
        #1;
        check("reset_read_data", read_data, 32'd0);
        check("reset_bus_error", {31'd0, bus_error}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Byte-lane extraction, high bits zero.
        st(32'h10, 2'd2, 32'h1122_3344);
        ld(32'h10, 2'd0, 32'h0000_0044, "ld_b0");
        ld(32'h11, 2'd0, 32'h0000_0033, "ld_b1");
        ld(32'h12, 2'd0, 32'h0000_0022, "ld_b2");
        ld(32'h13, 2'd0, 32'h0000_0011, "ld_b3");
        ld(32'h12, 2'd1, 32'h0000_1122, "ld_h_hi");
        ld(32'h10, 2'd2, 32'h1122_3344, "ld_w");

        // Sub-word stores only touch their lanes and only use the low bits of write_data.
        st(32'h20, 2'd2, 32'h0000_0000);
        st(32'h21, 2'd0, 32'h1234_56AA);
        ld(32'h20, 2'd2, 32'h0000_AA00, "st_byte");
        st(32'h22, 2'd1, 32'hDEAD_BEEF);
        ld(32'h20, 2'd2, 32'hBEEF_AA00, "st_half");

        @(negedge clock);
        @(negedge clock);
        check("idle_hold", read_data, 32'hBEEF_AA00);

        // Read and write together: write happens, old data returned.
        acc(1'b1, 1'b1, 32'h20, 2'd2, 32'h5566_7788, 32'hBEEF_AA00, "rw_old");
        ld(32'h20, 2'd2, 32'h5566_7788, "rw_new");

        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            st(32'h100 + 32'(4 * i), 2'd2, v);
            ld(32'h100 + 32'(4 * i) + 32'(i), 2'd0, (v >> (8 * i)) & 32'hFF, "rand_byte");
        end

        st(32'h0000_0FFC, 2'd2, 32'hCAFE_F00D);
        ld(32'h0000_0FFC, 2'd2, 32'hCAFE_F00D, "last_word");

        // Store in N, load in N+1, data visible in N+2.
        st(32'h40, 2'd2, 32'hA5A5_5A5A);
        ld(32'h40, 2'd2, 32'hA5A5_5A5A, "st_ld_b2b");
        check("no_error_yet", {31'd0, bus_error}, 32'd0);

        // Faults.
        ld(32'h11, 2'd1, 32'd0, "mis_half");
        check("err_set", {31'd0, bus_error}, 32'd1);
        ld(32'h10, 2'd2, 32'h1122_3344, "ram_unchanged");
        check("err_sticky", {31'd0, bus_error}, 32'd1);
        st(32'h12, 2'd2, 32'hFFFF_FFFF);
        ld(32'h10, 2'd2, 32'h1122_3344, "mis_store_dropped");
        ld(32'h10, 2'd3, 32'd0, "width3");
        ld(32'h10, 2'd2, 32'h1122_3344, "reload");
        ld(32'h0000_1000, 2'd2, 32'd0, "out_of_range");
        ld(32'h40, 2'd2, 32'hA5A5_5A5A, "reload2");

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b1;
        #1;
        check("async_rst_data", read_data, 32'd0);
        check("async_rst_err", {31'd0, bus_error}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        ld(32'h40, 2'd2, 32'hA5A5_5A5A, "ram_kept");

`ifdef RISCV_MTIMER_EN
        do_reset();
        ld(32'hFFFF_FF0C, 2'd2, 32'hFFFF_FFFF, "cmp_hi_reset");
        st(32'hFFFF_FF0C, 2'd2, 32'd0);
        check("irq_low", {31'd0, irq}, 32'd0);
        st(32'hFFFF_FF08, 2'd2, 32'd20);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (irq) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("irq_rise_seen", {31'd0, irq}, 32'd1);
        if (seen) ld(32'hFFFF_FF00, 2'd2, 32'd21, "mtime_at_irq");
        st(32'hFFFF_FF08, 2'd2, 32'hFFFF_FFFF);
        check("irq_before_fall", {31'd0, irq}, 32'd1);
        @(negedge clock);
        check("irq_fall", {31'd0, irq}, 32'd0);

        st(32'hFFFF_FF00, 2'd2, 32'hFFFF_FFFE);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        ld(32'hFFFF_FF04, 2'd2, 32'd1, "mtime_carry");
        check("timer_no_err", {31'd0, bus_error}, 32'd0);
        ld(32'hFFFF_FF00, 2'd0, 32'd0, "timer_byte");
        check("timer_byte_err", {31'd0, bus_error}, 32'd1);
`else
        do_reset();
        ld(32'h10, 2'd2, 32'h1122_3344, "pre_timer");
        ld(32'hFFFF_FF00, 2'd2, 32'd0, "no_timer_data");
        check("no_timer_err", {31'd0, bus_error}, 32'd1);
        held = read_data;
        @(negedge clock);
        check("no_timer_hold", read_data, held);
        check("no_timer_irq", {31'd0, irq}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
